// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one row at a time and reports each new key press.
//   Each row is driven low for c_Scan_div clock cycles. The columns are looked
//   at only on the last cycle of that dwell. The first closed key found
//   latches its code and raises a one-cycle o_valid. The scanner then stays on
//   that row until c_Release_cnt consecutive dwell samples show every column idle.
//
// Ports
//   i_clk      in   1  clock, all state changes on its rising edge
//   i_rst      in   1  synchronous active-high reset
//   i_col      in   4  debounced column lines, active-low
//   o_row      out  4  row drive, active-low, exactly one bit low
//   o_key      out  4  last detected key code {row[1:0], col[1:0]}
//   o_valid    out  1  one-cycle pulse per new key press
//   o_pressed  out  1  high while a detected key is held
module keypad_scanner #(
  parameter int c_Scan_div    = 50000,
  parameter int c_Release_cnt = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic [3:0] o_key,
  output logic       o_valid,
  output logic       o_pressed
);

  localparam int c_Div_w = ($clog2(c_Scan_div) < 1) ? 1 : $clog2(c_Scan_div);
  localparam logic [c_Div_w-1:0] c_Div_last = c_Div_w'(c_Scan_div - 1);
  localparam logic [3:0] c_Rel = 4'(c_Release_cnt);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } t_state;

  t_state             r_state;
  logic [c_Div_w-1:0] r_cnt;
  logic [1:0]         r_row;
  logic [3:0]         r_row_drv;
  logic [3:0]         r_idle;
  logic [3:0]         r_key;
  logic               r_valid;
  logic               r_pressed;

  t_state             w_state_nxt;
  logic [c_Div_w-1:0] w_cnt_nxt;
  logic [1:0]         w_row_nxt;
  logic [3:0]         w_idle_nxt;
  logic [3:0]         w_key_nxt;
  logic               w_valid_nxt;
  logic               w_pressed_nxt;
  logic               w_eod;
  logic               w_any_low;
  logic [1:0]         w_low_col;

  assign w_eod     = (r_cnt == c_Div_last);
  assign w_any_low = (i_col != 4'hF);

  // Free-running dwell counter; it never stops, so every state sees the same dwell grid.
  always_comb begin
    w_cnt_nxt = r_cnt + c_Div_w'(1);
    if (w_eod) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + c_Div_w'(1);
    end
  end

  // Priority encoder: lowest-numbered closed column wins.
  always_comb begin
    w_low_col = 2'd3;
    if (!i_col[0]) begin
      w_low_col = 2'd0;
    end else if (!i_col[1]) begin
      w_low_col = 2'd1;
    end else if (!i_col[2]) begin
      w_low_col = 2'd2;
    end else begin
      w_low_col = 2'd3;
    end
  end

  // Next-state and next-output logic of the scan FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_idle_nxt    = r_idle;
    w_key_nxt     = r_key;
    w_valid_nxt   = 1'b0;
    w_pressed_nxt = 1'b0;
    case (r_state)
      SCAN: begin
        w_idle_nxt = 4'd0;
        if (w_eod) begin
          if (w_any_low) begin
            // Row stays put so the held key can be watched for release.
            w_state_nxt   = PRESS;
            w_key_nxt     = {r_row, w_low_col};
            w_valid_nxt   = 1'b1;
            w_pressed_nxt = 1'b1;
          end else begin
            w_row_nxt = r_row + 2'd1;
          end
        end else begin
          w_row_nxt = r_row;
        end
      end
      PRESS: begin
        w_state_nxt   = HOLD;
        w_idle_nxt    = 4'd0;
        w_pressed_nxt = 1'b1;
      end
      HOLD: begin
        w_pressed_nxt = 1'b1;
        if (w_eod) begin
          if (i_col == 4'hF) begin
            if ((r_idle + 4'd1) == c_Rel) begin
              w_idle_nxt    = 4'd0;
              w_row_nxt     = r_row + 2'd1;
              w_state_nxt   = SCAN;
              w_pressed_nxt = 1'b0;
            end else begin
              w_idle_nxt = r_idle + 4'd1;
            end
          end else begin
            // Any closed column during the dwell sample restarts the release count.
            w_idle_nxt = 4'd0;
          end
        end else begin
          w_idle_nxt = r_idle;
        end
      end
      default: begin
        w_state_nxt   = SCAN;
        w_idle_nxt    = 4'd0;
        w_pressed_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SCAN;
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_row_drv <= 4'b1110;
      r_idle    <= 4'd0;
      r_key     <= 4'd0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_row     <= w_row_nxt;
      r_row_drv <= ~(4'b0001 << w_row_nxt);
      r_idle    <= w_idle_nxt;
      r_key     <= w_key_nxt;
      r_valid   <= w_valid_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  assign o_row     = r_row_drv;
  assign o_key     = r_key;
  assign o_valid   = r_valid;
  assign o_pressed = r_pressed;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter c_Scan_div, default 50000, SHALL set clock cycles each row is driven (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter c_Release_cnt, default 2, SHALL set consecutive all-idle samples required to declare key release; legal range 1..15.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 i_col  input  4  SHALL carry debounced column lines, active-low (0 = key closed on driven row).
REQ-006 o_row  output 4  SHALL drive keypad rows, active-low, exactly one bit low at all times.
REQ-007 o_key  output 4  SHALL hold the code of the last detected key, {row[1:0], col[1:0]}.
REQ-008 o_valid output 1  SHALL pulse high for one cycle per new key press.
REQ-009 o_pressed output 1  SHALL be high while a detected key is held.

Function
REQ-010 Block SHALL implement states SCAN, PRESS, HOLD.
REQ-011 Dwell counter SHALL count 0..c_Scan_div-1 and wrap to 0; end-of-dwell is the cycle it equals c_Scan_div-1.
REQ-012 Row index SHALL be 2 bits; o_row SHALL equal ~(4'b0001 << row index).
REQ-013 SCAN: i_col SHALL be sampled only at end-of-dwell; if all high, row index SHALL increment (3 wraps to 0) on the same edge.
REQ-014 SCAN: if any i_col bit low at end-of-dwell, block SHALL capture row index and lowest-numbered low column, keep row index unchanged, go to PRESS.
REQ-015 PRESS: lasts exactly one cycle; o_valid=1, o_key updated to captured code in that cycle; next state HOLD.
REQ-016 o_valid SHALL be registered; press latency = 1 cycle from the end-of-dwell sample edge to o_valid high.
REQ-017 HOLD: row index frozen; at each end-of-dwell, if i_col==4'b1111 an idle counter SHALL increment, otherwise reset to 0.
REQ-018 HOLD: when idle counter reaches c_Release_cnt, block SHALL clear idle counter, advance row index by one (wrap), go to SCAN.
REQ-019 o_pressed SHALL be 1 in PRESS and HOLD, 0 in SCAN.
REQ-020 Multiple simultaneous keys on one row: lowest column wins; keys on other rows ignored until release.
REQ-021 Additional keys pressed or released during HOLD SHALL NOT generate o_valid nor change o_key.
REQ-022 o_key SHALL retain its value after release until the next PRESS.
REQ-023 i_col changes between end-of-dwell cycles SHALL have no effect.
REQ-024 Dwell counter SHALL run continuously in all states, including PRESS.

Reset
REQ-025 While i_rst high at a clock edge: state=SCAN, row index=0 (o_row=4'b1110), dwell and idle counters=0, o_key=0, o_valid=0, o_pressed=0.
REQ-026 Reset SHALL take priority over all transitions, including reset asserted in PRESS or HOLD; no o_valid pulse SHALL follow reset.
REQ-027 Scanning SHALL resume from row 0, count 0 on the first edge after i_rst deasserts.

Verification (c_Scan_div=4, c_Release_cnt=2)
REQ-028 Idle i_col=4'hF for 32 cycles after reset -> o_row sequence 1110,1101,1011,0111,1110 each held 4 cycles; o_valid never high.
REQ-029 Press row 2/col 1 (i_col=4'b1101 while o_row=1011) -> one-cycle o_valid, o_key=4'h9, o_pressed high, o_row held 1011.
REQ-030 Release in HOLD -> after 2 idle end-of-dwell samples o_pressed falls, o_row advances to 0111, o_key stays 4'h9.
REQ-031 Row 0 with i_col=4'b0110 -> o_key=4'h0 (lowest column wins); subsequent bounce to 4'b1110 during HOLD -> no further o_valid.
REQ-032 i_rst asserted during HOLD -> next edge o_row=1110, o_pressed=0, o_key=0; key still held -> fresh o_valid only when scan reaches its row.
REQ-033 Glitch i_col low for 1 cycle not at end-of-dwell -> no o_valid, scan continues unchanged.
